// File: rtl/password_candidate_gen_if.sv
// Candidate handshake bundle between the brute-force generator and the
// NTLM hashing datapath.
//   start  : pulse that begins enumeration (driven by controller)
//   stop   : halt request from the hash comparator
//   ready  : downstream accepts the current candidate
//   instr  : left-justified, zero-padded candidate, char i at [8i:8i+7]
//   length : number of valid characters in instr
//   valid  : instr/length hold a candidate not yet accepted
//   busy   : generator is enumerating
//   done   : space exhausted or stopped
interface password_candidate_gen_if;
  logic         start;
  logic         stop;
  logic         ready;
  logic [0:127] instr;
  logic [0:3]   length;
  logic         valid;
  logic         busy;
  logic         done;

  modport master (
    input  start, stop, ready,
    output instr, length, valid, busy, done
  );

  modport slave (
    output start, stop, ready,
    input  instr, length, valid, busy, done
  );
endinterface

// File: rtl/password_candidate_gen.sv
// Brute-force password candidate generator. Enumerates every string over
// [CHAR_MIN, CHAR_MAX] of length MIN_LEN..MAX_LEN, rightmost character
// counting fastest, one candidate per accepted valid/ready transfer.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : candidate handshake (master side), see password_candidate_gen_if
module password_candidate_gen #(
  parameter logic [7:0]  CHAR_MIN = 8'h61,
  parameter logic [7:0]  CHAR_MAX = 8'h7A,
  parameter int unsigned MIN_LEN  = 1,
  parameter int unsigned MAX_LEN  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  password_candidate_gen_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [0:127] instr_q, instr_d;
  logic [0:3]   length_q, length_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [0:127] adv_instr;
  logic [0:127] first_instr;
  logic [0:3]   adv_length;
  logic         carry;
  logic         last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      length_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      length_q <= length_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    carry       = 1'b1;
    adv_instr   = instr_q;
    adv_length  = length_q;
    first_instr = '0;
    state_d     = state_q;
    instr_d     = instr_q;
    length_d    = length_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = done_q;

    for (int unsigned k = 0; k < 16; k++) begin
      if (4'(k) < 4'(MIN_LEN)) first_instr[8*k +: 8] = CHAR_MIN;
    end

    // Odometer: walk from byte 15 down so the rightmost used byte sees the
    // incoming carry first; unused bytes are skipped by the length guard.
    for (int unsigned k = 0; k < 16; k++) begin
      if (carry && (4'(15 - k) < length_q)) begin
        if (instr_q[8*(15-k) +: 8] == CHAR_MAX) begin
          adv_instr[8*(15-k) +: 8] = CHAR_MIN;
        end else begin
          adv_instr[8*(15-k) +: 8] = instr_q[8*(15-k) +: 8] + 8'd1;
          carry = 1'b0;
        end
      end
    end

    // Carry out of byte 0: grow by one and fill every used byte, including
    // the newly used one, with CHAR_MIN.
    if (carry) begin
      adv_length = length_q + 4'd1;
      for (int unsigned k = 0; k < 16; k++) begin
        adv_instr[8*k +: 8] = (4'(k) <= length_q) ? CHAR_MIN : 8'h00;
      end
    end

    last = carry && (length_q == 4'(MAX_LEN));

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = RUN;
          instr_d  = first_instr;
          length_d = 4'(MIN_LEN);
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      RUN: begin
        if (bus.stop || (valid_q && bus.ready && last)) begin
          state_d = DONE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (valid_q && bus.ready) begin
          instr_d  = adv_instr;
          length_d = adv_length;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.instr  = instr_q;
  assign bus.length = length_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
